scudsp_dma_engine: RTL
======================

# scudsp_dma_engine

Parametrised SCU DSP DMA engine: moves COUNT 32-bit words between the external A/B-bus master port and a selected DSP data RAM bank, or into program RAM. It sits between the DSP instruction decoder, which drives START/DIR/BANK/ADDI/HOLD/COUNT from a DMA opcode, and the SCU bus arbiter. It generalises the fixed 4-bank, 8-bit-count DSP DMA with a parametrised bank count, count width and bus width, plus a hold-address restore mode and explicit DONE signalling.

## Interface
- BANKS, 4, number of data RAM banks (power of two, ≥2)
- CNT_W, 8, transfer count width
- BUS_AW, 27, byte address width of bus port
- CLK  in  1  system clock
- RST_N  in  1  reset, asynchronous, active-low
- CE  in  1  clock enable; all state frozen when 0
- START  in  1  one-cycle start pulse (accepted only when BUSY=0)
- DIR  in  1  0: bus→RAM, 1: RAM→bus
- PRG  in  1  with DIR=0, destination is program RAM
- BANK  in  $clog2(BANKS)  data RAM bank select
- ADDI  in  3  bus address increment code
- HOLD  in  1  1: bus address register restored to start value at end
- COUNT  in  CNT_W  word count; 0 means 2^CNT_W
- RA0_WR / WA0_WR  in  1  load read / write base address register
- D1_DATA  in  BUS_AW-2  longword address for RA0/WA0 load
- BUS_A  out  BUS_AW  byte address, low two bits always 0
- BUS_DO  out  32  write data;  BUS_DI  in  32  read data
- BUS_REQ  out  1;  BUS_WE  out  1;  BUS_ACK  in  1
- RAM_SEL  out  $clog2(BANKS);  RAM_Q  in  32  muxed bank read data (valid one cycle after RAM_RE)
- RAM_RE  out  1;  RAM_WE  out  BANKS one-hot;  RAM_D  out  32
- CT_INC  out  BANKS  one-hot pulse: increment that bank's CT
- PRG_WE  out  1;  PRG_A  out  8;  PRG_D  out  32
- BUSY  out  1  (T0 flag);  DONE  out  1  one-cycle pulse at completion

## Operation
- States: IDLE, RD (RAM read), REQ (bus request), WR (RAM/PRG write), FIN.
- IDLE: on START latch DIR/PRG/BANK/ADDI/HOLD/COUNT; snapshot active address register (RA0 if DIR=0, WA0 if DIR=1); BUSY←1; go REQ (DIR=0) or RD (DIR=1); PRG_A←0 when PRG.
- DIR=0: REQ holds BUS_REQ=1, BUS_WE=0, BUS_A={RA0,2'b00} until BUS_ACK; on ACK capture BUS_DI, go WR. WR: RAM_WE[BANK]=1 and CT_INC[BANK]=1 (or PRG_WE=1, PRG_A++ if PRG); count−1; address += inc; count 0 → FIN else REQ.
- DIR=1: RD pulses RAM_RE with RAM_SEL=BANK, CT_INC[BANK]=1; next cycle REQ with BUS_WE=1, BUS_DO=RAM_Q (registered, stable through REQ); on ACK count−1, address += inc; count 0 → FIN else RD.
- Increment: ADDI=0 → 0; ADDI=k>0 → 2^(k−1) longwords (4…256 bytes). Address wraps modulo 2^(BUS_AW−2).
- FIN: DONE=1, BUSY←0; if HOLD, active register restored to snapshot; → IDLE.
- START while BUSY ignored. RA0_WR/WA0_WR while BUSY ignored; when idle, load D1_DATA next edge. PRG with DIR=1 treated as PRG=0.

## Timing
- Reset: state IDLE; RA0, WA0, PRG_A, count = 0; BUS_REQ, BUS_WE, RAM_RE, RAM_WE, CT_INC, PRG_WE, BUSY, DONE = 0; BUS_A, BUS_DO, RAM_D, PRG_D = 0.
- BUSY high the cycle after START; BUS_REQ first high same cycle (DIR=0) or one cycle later (DIR=1).
- ACK sampled only while BUS_REQ=1; ACK with REQ low ignored. Minimum 2 cycles/word (ACK on first REQ cycle).
- DONE pulses the cycle after the final WR/ACK; BUSY falls with DONE.
- Reset mid-transfer aborts instantly; no DONE issued.
- CE=0 stalls everything including ACK sampling; outputs hold.

## Structure
- Package scudsp_dma_pkg: state enum, DMAIncr(code) function returning longword increment, reset constants.
- One sub-module scudsp_dma_agen: RA0/WA0 registers, snapshot, increment, HOLD restore.

## Test plan
- RA0=0x100, DIR=0, BANK=2, ADDI=1, COUNT=3, ACK immediate -> BUS_A 0x400,0x404,0x408; RAM_WE=0100 three times; DONE at cycle 7; RA0=0x103.
- DIR=1, WA0=0x20, ADDI=3, HOLD=1, COUNT=2, ACK delayed 3 cycles -> BUS_A 0x80,0x90; BUS_DO equals RAM_Q per word; WA0=0x20 after DONE.
- DIR=0, PRG=1, COUNT=0 (CNT_W=8) -> 256 PRG_WE pulses, PRG_A 0..255, no RAM_WE.
- RA0=0x3FFFFFF (BUS_AW=28), ADDI=1, COUNT=2 -> second BUS_A wraps to 0.
- START and RA0_WR asserted mid-transfer -> both ignored; RST_N low mid-transfer -> BUS_REQ, BUSY 0 immediately, no DONE.
- CE low for 4 cycles while ACK high -> no progress until CE returns.

Source files
------------

// File: rtl/scudsp_dma_pkg.sv
// ============================================================================
// Module   : scudsp_dma_pkg
// Brief    : Shared types, reset constants and increment decode for the
//            SCU DSP DMA engine.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package scudsp_dma_pkg;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_RD   = 3'd1,
      S_REQ  = 3'd2,
      S_WR   = 3'd3,
      S_FIN  = 3'd4
   } dma_state_t;

   localparam logic [31:0] C_DATA_RST  = 32'd0;
   localparam logic [7:0]  C_PRG_A_RST = 8'd0;

   // Code 0 holds the address; code k steps by 2^(k-1) longwords.
   function automatic logic [6:0] DMAIncr(input logic [2:0] code);
      logic [6:0] inc;
      inc = 7'd0;
      if (code != 3'd0)
         inc = 7'd1 << (code - 3'd1);
      return inc;
   endfunction

endpackage

`default_nettype wire

// File: rtl/scudsp_dma_agen.sv
// ============================================================================
// Module   : scudsp_dma_agen
// Brief    : RA0/WA0 longword address registers with start snapshot,
//            per-word increment and end-of-transfer hold restore.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module scudsp_dma_agen
   import scudsp_dma_pkg::*;
#(
   parameter int LA_W = 25
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            ce,
   input  logic            ld_en,
   input  logic            ra0_wr,
   input  logic            wa0_wr,
   input  logic [LA_W-1:0] d1_data,
   input  logic            snap,
   input  logic            dir_in,
   input  logic            dir_act,
   input  logic            step,
   input  logic            restore,
   input  logic [2:0]      addi,
   output logic [LA_W-1:0] start_addr,
   output logic [LA_W-1:0] cur_addr,
   output logic [LA_W-1:0] nxt_addr
);

   logic [LA_W-1:0] r_ra0;
   logic [LA_W-1:0] r_wa0;
   logic [LA_W-1:0] r_snap;
   logic [LA_W-1:0] w_inc;
   logic [LA_W-1:0] w_upd;

   assign w_inc      = LA_W'(DMAIncr(addi));
   assign start_addr = dir_in  ? r_wa0 : r_ra0;
   assign cur_addr   = dir_act ? r_wa0 : r_ra0;
   assign nxt_addr   = cur_addr + w_inc;
   assign w_upd      = step ? nxt_addr : r_snap;

   // Loads are only enabled while idle, so they never collide with step/restore.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ra0  <= '0;
         r_wa0  <= '0;
         r_snap <= '0;
      end else if (ce) begin
         if (snap)
            r_snap <= start_addr;
         if (ld_en && ra0_wr)
            r_ra0 <= d1_data;
         if (ld_en && wa0_wr)
            r_wa0 <= d1_data;
         if (step || restore) begin
            if (dir_act)
               r_wa0 <= w_upd;
            else
               r_ra0 <= w_upd;
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/scudsp_dma_engine.sv
// ============================================================================
// Module   : scudsp_dma_engine
// Brief    : SCU DSP DMA sequencer moving words between the A/B-bus master
//            port and a DSP data RAM bank or program RAM.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module scudsp_dma_engine
   import scudsp_dma_pkg::*;
#(
   parameter int BANKS  = 4,
   parameter int CNT_W  = 8,
   parameter int BUS_AW = 27
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     ce,
   input  logic                     start,
   input  logic                     dir,
   input  logic                     prg,
   input  logic [$clog2(BANKS)-1:0] bank,
   input  logic [2:0]               addi,
   input  logic                     hold,
   input  logic [CNT_W-1:0]         count,
   input  logic                     ra0_wr,
   input  logic                     wa0_wr,
   input  logic [BUS_AW-3:0]        d1_data,
   output logic [BUS_AW-1:0]        bus_a,
   output logic [31:0]              bus_do,
   input  logic [31:0]              bus_di,
   output logic                     bus_req,
   output logic                     bus_we,
   input  logic                     bus_ack,
   output logic [$clog2(BANKS)-1:0] ram_sel,
   input  logic [31:0]              ram_q,
   output logic                     ram_re,
   output logic [BANKS-1:0]         ram_we,
   output logic [31:0]              ram_d,
   output logic [BANKS-1:0]         ct_inc,
   output logic                     prg_we,
   output logic [7:0]               prg_a,
   output logic [31:0]              prg_d,
   output logic                     busy,
   output logic                     done
);

   localparam int BW   = $clog2(BANKS);
   localparam int LA_W = BUS_AW - 2;

   dma_state_t       r_state;
   logic             r_dir;
   logic             r_prg;
   logic             r_hold;
   logic             r_cap;
   logic [BW-1:0]    r_bank;
   logic [2:0]       r_addi;
   logic [CNT_W-1:0] r_cnt;
   logic [31:0]      r_bus_do;

   logic             w_idle;
   logic             w_ack;
   logic             w_last;
   logic [BANKS-1:0] w_oh;
   logic [BANKS-1:0] w_in_oh;
   logic [LA_W-1:0]  w_start;
   logic [LA_W-1:0]  w_cur;
   logic [LA_W-1:0]  w_nxt;

   assign w_idle  = (r_state == S_IDLE);
   assign w_ack   = (r_state == S_REQ) && bus_req && bus_ack;
   assign w_last  = (r_cnt == CNT_W'(1));
   assign w_oh    = BANKS'(1) << r_bank;
   assign w_in_oh = BANKS'(1) << bank;

   // RAM_Q only becomes valid in the first REQ cycle, so it is passed through
   // then and held from the register for the rest of the request.
   assign bus_do = r_cap ? ram_q : r_bus_do;

   scudsp_dma_agen #(
      .LA_W (LA_W)
   ) u_agen (
      .clk        (clk),
      .rst_n      (rst_n),
      .ce         (ce),
      .ld_en      (w_idle),
      .ra0_wr     (ra0_wr),
      .wa0_wr     (wa0_wr),
      .d1_data    (d1_data),
      .snap       (w_idle && start),
      .dir_in     (dir),
      .dir_act    (r_dir),
      .step       ((r_state == S_WR) || (w_ack && r_dir)),
      .restore    ((r_state == S_FIN) && r_hold),
      .addi       (r_addi),
      .start_addr (w_start),
      .cur_addr   (w_cur),
      .nxt_addr   (w_nxt)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= S_IDLE;
         r_dir    <= 1'b0;
         r_prg    <= 1'b0;
         r_hold   <= 1'b0;
         r_cap    <= 1'b0;
         r_bank   <= '0;
         r_addi   <= 3'd0;
         r_cnt    <= '0;
         r_bus_do <= C_DATA_RST;
         bus_a    <= '0;
         bus_req  <= 1'b0;
         bus_we   <= 1'b0;
         ram_sel  <= '0;
         ram_re   <= 1'b0;
         ram_we   <= '0;
         ram_d    <= C_DATA_RST;
         ct_inc   <= '0;
         prg_we   <= 1'b0;
         prg_a    <= C_PRG_A_RST;
         prg_d    <= C_DATA_RST;
         busy     <= 1'b0;
         done     <= 1'b0;
      end else if (ce) begin
         ram_re <= 1'b0;
         ram_we <= '0;
         ct_inc <= '0;
         prg_we <= 1'b0;
         done   <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_dir   <= dir;
                  r_prg   <= prg & ~dir;
                  r_bank  <= bank;
                  r_addi  <= addi;
                  r_hold  <= hold;
                  r_cnt   <= count;
                  ram_sel <= bank;
                  busy    <= 1'b1;
                  if (prg && !dir)
                     prg_a <= C_PRG_A_RST;
                  if (dir) begin
                     r_state <= S_RD;
                     ram_re  <= 1'b1;
                     ct_inc  <= w_in_oh;
                  end else begin
                     r_state <= S_REQ;
                     bus_req <= 1'b1;
                     bus_we  <= 1'b0;
                     bus_a   <= {w_start, 2'b00};
                  end
               end
            end
            S_RD: begin
               r_state <= S_REQ;
               bus_req <= 1'b1;
               bus_we  <= 1'b1;
               bus_a   <= {w_cur, 2'b00};
               r_cap   <= 1'b1;
            end
            S_REQ: begin
               if (r_cap) begin
                  r_cap    <= 1'b0;
                  r_bus_do <= ram_q;
               end
               if (w_ack) begin
                  bus_req <= 1'b0;
                  bus_we  <= 1'b0;
                  if (!r_dir) begin
                     r_state <= S_WR;
                     ram_d   <= bus_di;
                     prg_d   <= bus_di;
                     if (r_prg) begin
                        prg_we <= 1'b1;
                     end else begin
                        ram_we <= w_oh;
                        ct_inc <= w_oh;
                     end
                  end else begin
                     r_cnt <= r_cnt - 1'b1;
                     if (w_last) begin
                        r_state <= S_FIN;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                     end else begin
                        r_state <= S_RD;
                        ram_re  <= 1'b1;
                        ct_inc  <= w_oh;
                     end
                  end
               end
            end
            S_WR: begin
               r_cnt <= r_cnt - 1'b1;
               if (r_prg)
                  prg_a <= prg_a + 8'd1;
               if (w_last) begin
                  r_state <= S_FIN;
                  busy    <= 1'b0;
                  done    <= 1'b1;
               end else begin
                  r_state <= S_REQ;
                  bus_req <= 1'b1;
                  bus_a   <= {w_nxt, 2'b00};
               end
            end
            S_FIN: begin
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

`default_nettype wire
